// File: rtl/ibex_rvfi_trace_buf.sv
// RVFI retirement-trace capture buffer (stream / trap-filter / wrap-and-trigger) with a valid/ready drain port.
// Record visible 1 cycle after capture; drain stalls never reach the core (stream modes drop when full, wrap mode overwrites oldest).
module ibex_rvfi_trace_buf #(
    parameter int unsigned Depth    = 16,
    parameter int unsigned PostTrig = 8,
    parameter bit          CapTagEn = 1'b1,
    parameter int unsigned DropW    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     rvfi_valid_i,
    input  logic [31:0]              rvfi_pc_rdata_i,
    input  logic [31:0]              rvfi_insn_i,
    input  logic [4:0]               rvfi_rd_addr_i,
    input  logic [31:0]              rvfi_rd_wdata_i,
    input  logic                     rvfi_rd_tag_i,
    input  logic                     rvfi_trap_i,
    input  logic                     rvfi_intr_i,
    input  logic [1:0]               mode_i,
    input  logic [31:0]              trig_pc_i,
    input  logic                     clear_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              rec_pc_o,
    output logic [31:0]              rec_insn_o,
    output logic [31:0]              rec_rd_wdata_o,
    output logic [4:0]               rec_rd_addr_o,
    output logic                     rec_rd_tag_o,
    output logic                     rec_trap_o,
    output logic                     rec_intr_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic [DropW-1:0]         drop_cnt_o,
    output logic                     frozen_o
);
    localparam int unsigned   AW        = $clog2(Depth);
    localparam int unsigned   CW        = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(Depth);
    localparam logic [CW-1:0] POST_INIT = CW'(PostTrig);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [4:0]  rd_addr;
        logic        rd_tag;
        logic        trap;
        logic        intr;
    } rec_t;

    typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} state_t;

    rec_t             mem [Depth];
    rec_t             wr_rec;
    rec_t             rd_rec;
    logic [AW-1:0]    wp, rp;
    logic [CW-1:0]    cnt, post_cnt, post_cnt_nxt;
    logic [DropW-1:0] drop_cnt;
    state_t           state, state_nxt;
    logic             pop, full, trig, elig, push, overwrite, drop;

    assign pop  = (cnt != '0) && out_ready_i;
    assign full = (cnt == FULL);
    assign trig = rvfi_valid_i && (rvfi_trap_i || (rvfi_pc_rdata_i == trig_pc_i));

    assign wr_rec = '{pc: rvfi_pc_rdata_i, insn: rvfi_insn_i, wdata: rvfi_rd_wdata_i,
                      rd_addr: rvfi_rd_addr_i, rd_tag: rvfi_rd_tag_i & CapTagEn,
                      trap: rvfi_trap_i, intr: rvfi_intr_i};

    always_comb begin
        elig         = 1'b0;
        push         = 1'b0;
        overwrite    = 1'b0;
        drop         = 1'b0;
        state_nxt    = state;
        post_cnt_nxt = post_cnt;

        case (mode_i)
            2'd1:    elig = rvfi_valid_i;
            2'd2:    elig = rvfi_valid_i && ((state == ARMED) || (state == POST));
            2'd3:    elig = rvfi_valid_i && (rvfi_trap_i || rvfi_intr_i);
            default: elig = 1'b0;
        endcase

        // Wrap mode never refuses a record: a full buffer sheds its oldest entry instead.
        if (mode_i == 2'd2) begin
            push      = elig;
            overwrite = elig && full && !pop;
        end else begin
            push = elig && (!full || pop);
            drop = elig && full && !pop;
        end

        if (mode_i != 2'd2) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = ARMED;
                ARMED: begin
                    if (trig) begin
                        post_cnt_nxt = POST_INIT;
                        if (PostTrig == 0) state_nxt = FROZEN;
                        else               state_nxt = POST;
                    end
                end
                POST: begin
                    if (push) begin
                        post_cnt_nxt = post_cnt - CW'(1);
                        if (post_cnt == CW'(1)) state_nxt = FROZEN;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            drop_cnt <= '0;
            post_cnt <= '0;
            state    <= IDLE;
        end else if (clear_i) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            drop_cnt <= '0;
            post_cnt <= '0;
            state    <= IDLE;
        end else begin
            if (push)              wp <= wp + AW'(1);
            if (pop || overwrite)  rp <= rp + AW'(1);
            cnt <= cnt + CW'(push && !overwrite) - CW'(pop);
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DropW'(1);
            post_cnt <= post_cnt_nxt;
            state    <= state_nxt;
        end
    end

    // Storage is deliberately unreset; out_valid_o qualifies the read side.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) mem[wp] <= wr_rec;
    end

    assign rd_rec         = mem[rp];
    assign out_valid_o    = (cnt != '0);
    assign rec_pc_o       = rd_rec.pc;
    assign rec_insn_o     = rd_rec.insn;
    assign rec_rd_wdata_o = rd_rec.wdata;
    assign rec_rd_addr_o  = rd_rec.rd_addr;
    assign rec_rd_tag_o   = CapTagEn ? rd_rec.rd_tag : 1'b0;
    assign rec_trap_o     = rd_rec.trap;
    assign rec_intr_o     = rd_rec.intr;
    assign count_o        = cnt;
    assign drop_cnt_o     = drop_cnt;
    assign frozen_o       = (state == FROZEN);
endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Scoreboard bench for ibex_rvfi_trace_buf: directed retirement sequences queue their expected drain records; a negedge monitor checks every pop.
module tb_ibex_rvfi_trace_buf;
    logic        clk_i, rst_ni;
    logic        rvfi_valid_i;
    logic [31:0] rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i, trig_pc_i;
    logic [4:0]  rvfi_rd_addr_i;
    logic        rvfi_rd_tag_i, rvfi_trap_i, rvfi_intr_i;
    logic [1:0]  mode_i;
    logic        clear_i, out_valid_o, out_ready_i;
    logic [31:0] rec_pc_o, rec_insn_o, rec_rd_wdata_o;
    logic [4:0]  rec_rd_addr_o;
    logic        rec_rd_tag_o, rec_trap_o, rec_intr_o;
    logic [4:0]  count_o;
    logic [15:0] drop_cnt_o;
    logic        frozen_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        trap;
        logic        intr;
    } exp_t;
    exp_t q[$];

    ibex_rvfi_trace_buf #(.Depth(16), .PostTrig(8), .CapTagEn(1'b1), .DropW(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_insn_i(rvfi_insn_i),
        .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_rd_tag_i(rvfi_rd_tag_i),
        .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i), .mode_i(mode_i), .trig_pc_i(trig_pc_i),
        .clear_i(clear_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .rec_pc_o(rec_pc_o), .rec_insn_o(rec_insn_o), .rec_rd_wdata_o(rec_rd_wdata_o),
        .rec_rd_addr_o(rec_rd_addr_o), .rec_rd_tag_o(rec_rd_tag_o), .rec_trap_o(rec_trap_o),
        .rec_intr_o(rec_intr_o), .count_o(count_o), .drop_cnt_o(drop_cnt_o), .frozen_o(frozen_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next posedge whenever valid && ready at this negedge.
    always @(negedge clk_i) begin
        if (rst_ni && !clear_i && out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc 0x%08h expected no record", rec_pc_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("drain_pc", rec_pc_o, e.pc);
                chk("drain_insn", rec_insn_o, ~e.pc);
                chk("drain_wdata", rec_rd_wdata_o, e.pc + 32'h1000);
                chk("drain_flags", {24'd0, rec_rd_addr_o, rec_rd_tag_o, rec_trap_o, rec_intr_o},
                    {24'd0, e.pc[4:0], e.pc[0], e.trap, e.intr});
            end
        end
    end

    task automatic ret(input logic [31:0] pc, input logic trap, input logic intr);
        rvfi_valid_i    = 1'b1;
        rvfi_pc_rdata_i = pc;
        rvfi_insn_i     = ~pc;
        rvfi_rd_addr_i  = pc[4:0];
        rvfi_rd_wdata_i = pc + 32'h1000;
        rvfi_rd_tag_i   = pc[0];
        rvfi_trap_i     = trap;
        rvfi_intr_i     = intr;
        @(posedge clk_i); #1;
    endtask

    task automatic idle();
        rvfi_valid_i = 1'b0;
        rvfi_trap_i  = 1'b0;
        rvfi_intr_i  = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic expect_rec(input logic [31:0] pc, input logic trap, input logic intr);
        exp_t e;
        e.pc = pc; e.trap = trap; e.intr = intr;
        q.push_back(e);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        q.delete();
        @(posedge clk_i); #1;
        clear_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        out_ready_i = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid_o) && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        out_ready_i = 1'b0;
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d records left expected 0", name, q.size());
        end
        chk({name, "_count_empty"}, 32'(count_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; rvfi_valid_i = 1'b0; rvfi_pc_rdata_i = '0; rvfi_insn_i = '0;
        rvfi_rd_addr_i = '0; rvfi_rd_wdata_i = '0; rvfi_rd_tag_i = 1'b0; rvfi_trap_i = 1'b0;
        rvfi_intr_i = 1'b0; mode_i = 2'd0; trig_pc_i = '0; clear_i = 1'b0; out_ready_i = 1'b0;
        #22 rst_ni = 1'b1;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("rst_frozen", 32'(frozen_o), 32'd0);
        @(posedge clk_i); #1;

        // Stream mode overflow: 20 pushes, 16 kept, 4 dropped.
        mode_i = 2'd1;
        for (int i = 1; i <= 16; i++) expect_rec(32'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) ret(32'(i), 1'b0, 1'b0);
        idle();
        chk("s1_count", 32'(count_o), 32'd16);
        chk("s1_drop", 32'(drop_cnt_o), 32'd4);
        chk("s1_hold_pc", rec_pc_o, 32'd1);
        idle();
        chk("s1_hold_pc2", rec_pc_o, 32'd1);
        drain("s1");

        // Stream mode, push and pop every cycle.
        do_clear();
        chk("clr_drop", 32'(drop_cnt_o), 32'd0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            expect_rec(32'(1000 + i), 1'b0, 1'b0);
            ret(32'(1000 + i), 1'b0, 1'b0);
            if (i == 0) chk("latency_valid", 32'(out_valid_o), 32'd1);
            chk("s2_count", 32'(count_o), 32'd1);
        end
        idle();
        drain("s2");
        chk("s2_drop", 32'(drop_cnt_o), 32'd0);

        // Trap/interrupt filter.
        do_clear();
        mode_i = 2'd3;
        expect_rec(32'd203, 1'b1, 1'b0);
        expect_rec(32'd207, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) ret(32'(200 + i), i == 3, i == 7);
        idle();
        chk("s3_count", 32'(count_o), 32'd2);
        drain("s3");

        // Wrap mode, PC trigger at #30.
        mode_i = 2'd2;
        trig_pc_i = 32'd330;
        do_clear();
        idle();
        for (int i = 23; i <= 38; i++) expect_rec(32'(300 + i), 1'b0, 1'b0);
        for (int i = 1; i <= 50; i++) begin
            ret(32'(300 + i), 1'b0, 1'b0);
            if (i == 37) chk("s4_not_frozen", 32'(frozen_o), 32'd0);
            if (i == 38) chk("s4_frozen", 32'(frozen_o), 32'd1);
        end
        idle();
        chk("s4_count", 32'(count_o), 32'd16);
        chk("s4_head", rec_pc_o, 32'd323);
        drain("s4");
        chk("s4_frozen_after", 32'(frozen_o), 32'd1);

        // Wrap mode, trap at #5 with only 5 buffered.
        trig_pc_i = 32'hFFFF_FFF0;
        do_clear();
        idle();
        for (int i = 1; i <= 13; i++) expect_rec(32'(400 + i), i == 5, 1'b0);
        for (int i = 1; i <= 20; i++) ret(32'(400 + i), i == 5, 1'b0);
        idle();
        chk("s5_count", 32'(count_o), 32'd13);
        chk("s5_frozen", 32'(frozen_o), 32'd1);
        drain("s5");

        // Clear wins over simultaneous push and pop.
        mode_i = 2'd1;
        do_clear();
        for (int i = 1; i <= 18; i++) ret(32'(500 + i), 1'b0, 1'b0);
        idle();
        chk("s6_drop_before", 32'(drop_cnt_o), 32'd2);
        clear_i = 1'b1; out_ready_i = 1'b1;
        q.delete();
        ret(32'd600, 1'b0, 1'b0);
        clear_i = 1'b0; out_ready_i = 1'b0;
        rvfi_valid_i = 1'b0;
        chk("s6_count", 32'(count_o), 32'd0);
        chk("s6_valid", 32'(out_valid_o), 32'd0);
        chk("s6_drop", 32'(drop_cnt_o), 32'd0);

        // Asynchronous reset while in POST.
        mode_i = 2'd2;
        do_clear();
        idle();
        for (int i = 1; i <= 4; i++) ret(32'(700 + i), i == 2, 1'b0);
        rvfi_valid_i = 1'b0;
        chk("s7_count_pre", 32'(count_o), 32'd4);
        chk("s7_frozen_pre", 32'(frozen_o), 32'd0);
        #2;
        q.delete();
        rst_ni = 1'b0;
        #1;
        chk("s7_valid", 32'(out_valid_o), 32'd0);
        chk("s7_count", 32'(count_o), 32'd0);
        chk("s7_drop", 32'(drop_cnt_o), 32'd0);
        chk("s7_frozen", 32'(frozen_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ibex_rvfi_trace_buf.md
# ibex_rvfi_trace_buf

Parametrised retirement-trace capture buffer. It sits beside the CHERIoT Ibex core in the tracing top level and snoops the RVFI retirement stream, the same signals that feed the instruction tracer. Selected retirement records go into a circular buffer of configurable depth, in either streaming or wrap-and-trigger (flight-recorder) mode. A valid/ready drain port lets a debug agent or testbench read the buffer back without stalling the core.

## Interface
Parameters:
- Depth, 16, number of record slots; must be a power of two, minimum 4.
- PostTrig, 8, records captured after a trigger in wrap mode before freezing; must be less than Depth.
- CapTagEn, 1'b1, when 1 each record includes the rd capability tag bit; when 0 rec_rd_tag_o is tied 0.
- DropW, 16, width of the dropped-record counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- rvfi_valid_i  in  1  a retirement record is present this cycle.
- rvfi_pc_rdata_i  in  32  PC of the retiring instruction.
- rvfi_insn_i  in  32  instruction word.
- rvfi_rd_addr_i  in  5  destination register.
- rvfi_rd_wdata_i  in  32  destination write data.
- rvfi_rd_tag_i  in  1  tag bit of rvfi_rd_wcap.
- rvfi_trap_i  in  1  the instruction trapped.
- rvfi_intr_i  in  1  first instruction of a handler.
- mode_i  in  2  capture mode: 0 off, 1 stream, 2 wrap, 3 trap-filter stream.
- trig_pc_i  in  32  PC match trigger, used in wrap mode.
- clear_i  in  1  synchronous clear of buffer, counters and FSM.
- out_valid_o  out  1  a record is available at the drain port.
- out_ready_i  in  1  the consumer accepts the record.
- rec_pc_o, rec_insn_o, rec_rd_wdata_o  out  32 each  drain record fields.
- rec_rd_addr_o  out  5  drain record field.
- rec_rd_tag_o, rec_trap_o, rec_intr_o  out  1 each  drain record fields.
- count_o  out  $clog2(Depth)+1  current occupancy.
- drop_cnt_o  out  DropW  saturating count of records lost in stream modes.
- frozen_o  out  1  wrap-mode capture has frozen.

## Operation
- Storage: Depth-entry register array, write pointer wp and read pointer rp, each $clog2(Depth) bits and wrapping modulo Depth, plus an occupancy counter cnt.
- Eligible push:
  - Mode 1: rvfi_valid_i.
  - Mode 3: rvfi_valid_i && (rvfi_trap_i || rvfi_intr_i).
  - Mode 2: rvfi_valid_i while the FSM is in ARMED or POST.
  - Mode 0: never.
- Pop: out_valid_o && out_ready_i. out_valid_o = (cnt != 0). The rec_* outputs present entry[rp] combinationally from storage.
- Stream modes (1 and 3):
  - Push when cnt < Depth, or when a pop happens in the same cycle.
  - A push while cnt == Depth with no pop drops the record and increments drop_cnt_o, which saturates at all-ones.
- Wrap mode (2), FSM with states IDLE, ARMED, POST, FROZEN:
  - IDLE: moves to ARMED when mode_i == 2.
  - ARMED: every eligible push writes. If cnt == Depth and there is no pop, the oldest entry is overwritten: rp advances and cnt is unchanged. Trigger = rvfi_valid_i && (rvfi_trap_i || rvfi_pc_rdata_i == trig_pc_i). The triggering record is stored, the post counter is loaded with PostTrig, and the FSM moves to POST.
  - POST: each push decrements the post counter. The push that takes it to 0 moves the FSM to FROZEN.
  - FROZEN: no pushes; frozen_o = 1; draining is allowed.
- Leaving mode 2 (mode_i != 2) returns the FSM to IDLE. Buffer contents are retained.
- The drain port is usable in every mode and state.
- Simultaneous push and pop:
  - cnt is unchanged.
  - With cnt == 0, the pushed record does not bypass to the outputs; out_valid_o asserts the next cycle.
  - In wrap-mode overwrite, a push and a pop in the same cycle with cnt == Depth is an ordinary push+pop; there is no extra rp advance.
- clear_i has priority over all pushes and pops: wp = rp = cnt = 0, drop counter = 0, FSM = IDLE.

## Timing
- Reset values: out_valid_o 0, count_o 0, drop_cnt_o 0, frozen_o 0, FSM IDLE, wp = rp = 0.
- The rec_* outputs reflect entry[0]; storage is not reset, so rec_* are don't-care while out_valid_o = 0.
- Latency from an rvfi_valid_i edge to out_valid_o is 1 cycle, when the buffer was empty.
- The drain port follows standard valid/ready:
  - The record is held stable while out_valid_o && !out_ready_i.
  - The next record appears the cycle after an accepted pop.
- Sustained throughput is one push and one pop per cycle.
- count_o, drop_cnt_o and frozen_o are registered and update one cycle after the causing edge.
- An asynchronous reset mid-capture discards all state immediately. There is no partial-record recovery.

## Test plan
- Mode 1, Depth 16, 20 back-to-back retirements with out_ready_i = 0 -> count_o = 16, drop_cnt_o = 4; draining returns PCs 1..16 in order.
- Mode 1, push and pop every cycle for 100 cycles -> count_o stays at 1; no drops; no records lost or reordered.
- Mode 3, 10 retirements of which #3 has trap and #7 has intr -> exactly 2 records, trap then intr, with matching flags.
- Mode 2, PostTrig 8, 50 retirements with a PC match at #30 -> frozen_o = 1 after #38; the drain yields #23..#38, 16 records.
- Mode 2, trap at #5 with only 5 records buffered -> freeze after #13; the drain yields #1..#13 and count_o = 13.
- clear_i asserted in the same cycle as a push and a pop with a non-empty buffer -> next cycle count_o = 0, out_valid_o = 0, drop counter 0.
- Reset asserted mid-POST -> all outputs return to their reset values within the same cycle.
